// File: rtl/gpi_irq.sv
// gpi_irq: general-purpose input slot peripheral.
// Per-bit synchroniser, optional shared-tick debounce, rising/falling edge
// detection into sticky W1C status, and a maskable level interrupt.
module gpi_irq #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [W-1:0]  din,
    output logic          irq
);

    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [W-1:0]    W_ZERO  = {W{1'b0}};

    logic [W-1:0]    sync_q [SYNC_STAGES];
    logic [W-1:0]    sync_d [SYNC_STAGES];
    logic [W-1:0]    sampled_q, sampled_d;
    logic [W-1:0]    filtered_q, filtered_d;
    logic [W-1:0]    filt_dly_q, filt_dly_d;
    logic [W-1:0]    status_q, status_d;
    logic [W-1:0]    rise_en_q, rise_en_d;
    logic [W-1:0]    fall_en_q, fall_en_d;
    logic [W-1:0]    irq_en_q, irq_en_d;
    logic [DB_W-1:0] db_period_q, db_period_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    logic [W-1:0]    synced_s;
    logic [W-1:0]    stable_s;
    logic [W-1:0]    rise_s, fall_s;
    logic [W-1:0]    clr_s;
    logic            tick_s;
    logic            bypass_s;
    logic            wr_en_s;
    logic [31:0]     rd_mux_s;
    // read strobe has no side effects; upper write bits beyond W/DB_W are ignored
    logic            unused_s;

    assign unused_s = ^{read, wr_data};
    assign wr_en_s  = cs & write;
    assign synced_s = sync_q[SYNC_STAGES-1];
    assign bypass_s = (db_period_q == DB_ZERO);
    assign tick_s   = !bypass_s && (cnt_q == db_period_q);
    assign stable_s = ~(synced_s ^ sampled_q);
    assign rise_s   = filtered_q & ~filt_dly_q;
    assign fall_s   = ~filtered_q & filt_dly_q;
    assign clr_s    = (wr_en_s && addr == 5'd1) ? wr_data[W-1:0] : W_ZERO;

    // Synchroniser chain: stage 0 captures the raw asynchronous inputs
    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Tick counter: runs 0..P, cleared by a DB_PERIOD write and idle in bypass
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en_s && addr == 5'd5) begin
            cnt_d = DB_ZERO;
        end else if (bypass_s || tick_s) begin
            cnt_d = DB_ZERO;
        end else begin
            cnt_d = cnt_q + DB_ONE;
        end
    end

    // Debounce: accept a bit only when it agrees at two consecutive ticks
    always_comb begin
        sampled_d  = sampled_q;
        filtered_d = filtered_q;
        if (bypass_s) begin
            filtered_d = synced_s;
        end else if (tick_s) begin
            sampled_d  = synced_s;
            filtered_d = (synced_s & stable_s) | (filtered_q & ~stable_s);
        end else begin
            filtered_d = filtered_q;
        end
    end

    // Edge history and sticky status; a new edge beats a same-cycle W1C
    always_comb begin
        filt_dly_d = filtered_q;
        status_d   = (status_q & ~clr_s) | (rise_s & rise_en_q) | (fall_s & fall_en_q);
    end

    // Software-writable control registers
    always_comb begin
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        irq_en_d    = irq_en_q;
        db_period_d = db_period_q;
        if (wr_en_s) begin
            case (addr)
                5'd2:    rise_en_d   = wr_data[W-1:0];
                5'd3:    fall_en_d   = wr_data[W-1:0];
                5'd4:    irq_en_d    = wr_data[W-1:0];
                5'd5:    db_period_d = wr_data[DB_W-1:0];
                default: db_period_d = db_period_q;
            endcase
        end else begin
            db_period_d = db_period_q;
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= W_ZERO;
            end
            sampled_q   <= W_ZERO;
            filtered_q  <= W_ZERO;
            filt_dly_q  <= W_ZERO;
            status_q    <= W_ZERO;
            rise_en_q   <= W_ZERO;
            fall_en_q   <= W_ZERO;
            irq_en_q    <= W_ZERO;
            db_period_q <= DB_ZERO;
            cnt_q       <= DB_ZERO;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            sampled_q   <= sampled_d;
            filtered_q  <= filtered_d;
            filt_dly_q  <= filt_dly_d;
            status_q    <= status_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            irq_en_q    <= irq_en_d;
            db_period_q <= db_period_d;
            cnt_q       <= cnt_d;
        end
    end

    // Read mux: unused bits and unmapped indices read as zero
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr)
            5'd0:    rd_mux_s[W-1:0]    = filtered_q;
            5'd1:    rd_mux_s[W-1:0]    = status_q;
            5'd2:    rd_mux_s[W-1:0]    = rise_en_q;
            5'd3:    rd_mux_s[W-1:0]    = fall_en_q;
            5'd4:    rd_mux_s[W-1:0]    = irq_en_q;
            5'd5:    rd_mux_s[DB_W-1:0] = db_period_q;
            default: rd_mux_s           = 32'd0;
        endcase
    end

    assign rd_data = rd_mux_s;
    assign irq     = |(status_q & irq_en_q);

endmodule
